// File: rtl/sextium_io_responder.sv
// Sextium III I/O bus responder: four-phase io_read/io_write handshake with ioack,
// backed by an input FIFO (producer -> core) and an output FIFO (core -> sink).
// Optional wait states are built only when SEXTIUM_IO_WAITSTATE_EN is defined.
module sextium_io_responder #(
  parameter int DEPTH_LOG2 = 3
`ifdef SEXTIUM_IO_WAITSTATE_EN
  , parameter int WAIT_CYCLES = 2
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [15:0] io_bus_in,
  output logic [15:0] io_bus_out,
  output logic        ioack,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_ACK     = 3'd3
`ifdef SEXTIUM_IO_WAITSTATE_EN
    , S_DELAY = 3'd4
`endif
  } state_t;

  state_t r_state;
  state_t w_next_state;
  state_t w_after_serve;
  logic   r_is_read;
  logic   w_req_live;
  logic   w_ioack;

  logic [15:0]           r_in_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_in_wptr, r_in_rptr;
  logic [DEPTH_LOG2:0]   r_in_count;
  logic [15:0]           r_out_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_out_wptr, r_out_rptr;
  logic [DEPTH_LOG2:0]   r_out_count;
  logic [15:0]           r_io_bus_out;

  logic w_in_push, w_in_pop, w_out_push, w_out_pop;

  assign in_ready   = (r_in_count != CNT_FULL);
  assign out_valid  = (r_out_count != CNT_ZERO);
  assign out_data   = out_valid ? r_out_mem[r_out_rptr] : 16'h0000;
  assign io_bus_out = r_io_bus_out;
  assign ioack      = w_ioack;

  assign w_in_push  = in_valid & in_ready;
  assign w_in_pop   = (r_state == S_RD_WAIT) && (r_in_count != CNT_ZERO);
  assign w_out_push = (r_state == S_WR_WAIT) && (r_out_count != CNT_FULL);
  assign w_out_pop  = out_valid & out_ready;
  // The request that ends ACK is the one that was served, not whichever is high now.
  assign w_req_live = r_is_read ? io_read : io_write;

`ifdef SEXTIUM_IO_WAITSTATE_EN
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);
  logic [WCW-1:0] r_wait_cnt;

  assign w_after_serve = (WAIT_CYCLES > 0) ? S_DELAY : S_ACK;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= WCW'(0);
    end else if (r_state == S_DELAY) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end else begin
      r_wait_cnt <= WCW'(0);
    end
  end
`else
  assign w_after_serve = S_ACK;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_is_read <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE) begin
        r_is_read <= io_read;
      end else begin
        r_is_read <= r_is_read;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_read) begin
          w_next_state = S_RD_WAIT;
        end else if (io_write) begin
          w_next_state = S_WR_WAIT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (w_in_pop) w_next_state = w_after_serve;
        else          w_next_state = S_RD_WAIT;
      end
      S_WR_WAIT: begin
        if (w_out_push) w_next_state = w_after_serve;
        else            w_next_state = S_WR_WAIT;
      end
`ifdef SEXTIUM_IO_WAITSTATE_EN
      S_DELAY: begin
        if (r_wait_cnt == WAIT_LAST) w_next_state = S_ACK;
        else                         w_next_state = S_DELAY;
      end
`endif
      S_ACK: begin
        if (!w_req_live) w_next_state = S_IDLE;
        else             w_next_state = S_ACK;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_ioack = 1'b0;
    if (r_state == S_ACK) begin
      w_ioack = 1'b1;
    end else begin
      w_ioack = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_io_bus_out <= 16'h0000;
    end else if (w_in_pop) begin
      r_io_bus_out <= r_in_mem[r_in_rptr];
    end else begin
      r_io_bus_out <= r_io_bus_out;
    end
  end

  // Storage arrays are not reset; the counts alone define what is valid.
  always_ff @(posedge clock) begin
    if (w_in_push)  r_in_mem[r_in_wptr]   <= in_data;
    if (w_out_push) r_out_mem[r_out_wptr] <= io_bus_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_wptr  <= PTR_ZERO;
      r_in_rptr  <= PTR_ZERO;
      r_in_count <= CNT_ZERO;
    end else begin
      if (w_in_push) r_in_wptr <= r_in_wptr + PTR_ONE;
      if (w_in_pop)  r_in_rptr <= r_in_rptr + PTR_ONE;
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_count <= r_in_count + CNT_ONE;
        2'b01:   r_in_count <= r_in_count - CNT_ONE;
        default: r_in_count <= r_in_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_wptr  <= PTR_ZERO;
      r_out_rptr  <= PTR_ZERO;
      r_out_count <= CNT_ZERO;
    end else begin
      if (w_out_push) r_out_wptr <= r_out_wptr + PTR_ONE;
      if (w_out_pop)  r_out_rptr <= r_out_rptr + PTR_ONE;
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_count <= r_out_count + CNT_ONE;
        2'b01:   r_out_count <= r_out_count - CNT_ONE;
        default: r_out_count <= r_out_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sextium_io_responder.sv
// Self-checking bench for sextium_io_responder: per-cycle vector table plus
// hand-written sequences for stalls, FIFO-full back-pressure and reset mid-read.
module tb_sextium_io_responder;

`ifdef SEXTIUM_IO_WAITSTATE_EN
  localparam int WC = 3;
`else
  localparam int WC = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [15:0] io_bus_in = 16'h0000;
  logic [15:0] io_bus_out;
  logic        ioack;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  sextium_io_responder #(
    .DEPTH_LOG2(3)
`ifdef SEXTIUM_IO_WAITSTATE_EN
    , .WAIT_CYCLES(WC)
`endif
  ) dut (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
    .io_bus_in(io_bus_in), .io_bus_out(io_bus_out), .ioack(ioack),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, rd, wr;
    logic [15:0] bin;
    logic        iv;
    logic [15:0] idat;
    logic        ordy;
    logic        e_ack;
    logic [15:0] e_bus;
    logic        e_inrdy, e_ov;
    logic [15:0] e_od;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic rd, logic wr, logic [15:0] bin,
                              logic iv, logic [15:0] idat, logic ordy,
                              logic e_ack, logic [15:0] e_bus, logic e_inrdy,
                              logic e_ov, logic [15:0] e_od);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.bin = bin; v.iv = iv; v.idat = idat;
    v.ordy = ordy; v.e_ack = e_ack; v.e_bus = e_bus; v.e_inrdy = e_inrdy;
    v.e_ov = e_ov; v.e_od = e_od;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"}, {15'd0, ioack}, 16'h0000);
    chk({tag, "_bus"}, io_bus_out, 16'h0000);
    chk({tag, "_inrdy"}, {15'd0, in_ready}, 16'h0001);
    chk({tag, "_ov"}, {15'd0, out_valid}, 16'h0000);
    chk({tag, "_od"}, out_data, 16'h0000);
  endtask

  // Holds the current request until ioack or the cycle budget runs out.
  task automatic wait_ack(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (ioack) return;
    end
    lat = -1;
  endtask

  initial begin
    int lat;

`ifndef SEXTIUM_IO_WAITSTATE_EN
    //             rst rd   wr   bin      iv   idat     ordy  ack  bus      inrdy ov   od
    tbl.push_back(mk(1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1,16'h1234,1'b0, 1'b0,16'h0000,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1,16'hBEEF,1'b0, 1'b0,16'h0000,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b1,16'h1234,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h1234,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h1234,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b1,16'hBEEF,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'hBEEF,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1,16'h7777,1'b0, 1'b0,16'hBEEF,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b1,1'b1,16'h5555,1'b0,16'h0000,1'b0, 1'b0,16'hBEEF,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b1,1'b1,16'h5555,1'b0,16'h0000,1'b0, 1'b1,16'h7777,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h7777,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b1,16'h0042,1'b0,16'h0000,1'b0, 1'b0,16'h7777,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b1,16'h0042,1'b0,16'h0000,1'b0, 1'b1,16'h7777,1'b1,1'b1,16'h0042));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h7777,1'b1,1'b1,16'h0042));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1, 1'b0,16'h7777,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h7777,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0101,1'b0, 1'b0,16'h7777,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b1,16'h0101,1'b1,1'b0,16'h0000));
    tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0, 1'b0,16'h0101,1'b1,1'b0,16'h0000));

    foreach (tbl[k]) begin
      reset = tbl[k].rst; io_read = tbl[k].rd; io_write = tbl[k].wr;
      io_bus_in = tbl[k].bin; in_valid = tbl[k].iv; in_data = tbl[k].idat;
      out_ready = tbl[k].ordy;
      step();
      chk($sformatf("v%0d_ack", k), {15'd0, ioack}, {15'd0, tbl[k].e_ack});
      chk($sformatf("v%0d_bus", k), io_bus_out, tbl[k].e_bus);
      chk($sformatf("v%0d_inrdy", k), {15'd0, in_ready}, {15'd0, tbl[k].e_inrdy});
      chk($sformatf("v%0d_ov", k), {15'd0, out_valid}, {15'd0, tbl[k].e_ov});
      chk($sformatf("v%0d_od", k), out_data, tbl[k].e_od);
    end
    reset = 1'b0; io_read = 1'b0; io_write = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Read on an empty FIFO stalls until the producer delivers.
    io_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("stall_rd%0d_ack", i), {15'd0, ioack}, 16'h0000);
    end
    in_valid = 1'b1; in_data = 16'h00A5;
    step();
    in_valid = 1'b0;
    chk("push_edge_ack", {15'd0, ioack}, 16'h0000);
    step();
    chk("late_rd_ack", {15'd0, ioack}, 16'h0001);
    chk("late_rd_bus", io_bus_out, 16'h00A5);
    io_read = 1'b0;
    step();
    chk("late_rd_drop", {15'd0, ioack}, 16'h0000);

    // Fill the output FIFO with the consumer stalled.
    for (int k = 1; k <= 8; k++) begin
      io_write = 1'b1; io_bus_in = 16'(k);
      wait_ack(lat);
      chk($sformatf("wr%0d_lat", k), 16'(lat), 16'd2);
      chk($sformatf("wr%0d_head", k), out_data, 16'h0001);
      io_write = 1'b0;
      step();
      chk($sformatf("wr%0d_drop", k), {15'd0, ioack}, 16'h0000);
    end
    io_write = 1'b1; io_bus_in = 16'h0009;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wr9_stall%0d", i), {15'd0, ioack}, 16'h0000);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wr9_pop_ack", {15'd0, ioack}, 16'h0000);
    chk("wr9_pop_head", out_data, 16'h0002);
    step();
    chk("wr9_ack", {15'd0, ioack}, 16'h0001);
    io_write = 1'b0;
    step();
    chk("wr9_drop", {15'd0, ioack}, 16'h0000);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("drain%0d_ov", k), {15'd0, out_valid}, 16'h0001);
      chk($sformatf("drain%0d_od", k), out_data, 16'(k));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("drained_ov", {15'd0, out_valid}, 16'h0000);
    chk("drained_od", out_data, 16'h0000);

    // Fill the input FIFO, then reset in the middle of a read.
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'h0010 + 16'(k);
      step();
    end
    in_valid = 1'b0;
    chk("in_full_rdy", {15'd0, in_ready}, 16'h0000);
    out_ready = 1'b0;
    io_read = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state("mid_rst");
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst_stall%0d", i), {15'd0, ioack}, 16'h0000);
    end
    io_read = 1'b0;
`else
    step();
    reset = 1'b0;
    chk_reset_state("ws_rst");
    in_valid = 1'b1; in_data = 16'h3C3C;
    step();
    in_valid = 1'b0;
    io_read = 1'b1;
    wait_ack(lat);
    chk("ws_lat", 16'(lat), 16'(2 + WC));
    chk("ws_bus", io_bus_out, 16'h3C3C);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("ws_hold%0d", i), {15'd0, ioack}, 16'h0001);
    end
    io_read = 1'b0;
    step();
    chk("ws_drop", {15'd0, ioack}, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
